// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a 2-FF input synchroniser,
// mid-bit sampling, false-start rejection, break rejection (armed flag),
// framing-error detection and a one-cycle data-valid strobe.
// Optional parity bit: define UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 21000,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_W < 5 || DATA_W > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_cfg_check
    $error("uart_rx_param: unsupported parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic par_bad;
  logic perr_nxt;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_nxt;
  logic              rxd_m, rxd_s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              armed;
  logic              bit_done;
  logic              valid_nxt, ferr_nxt;

  assign bit_done = (cnt == CNT_FULL);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; all decisions use the synchronised line only.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (armed && !rxd_s) state_nxt = START;
      START:  if (cnt == CNT_HALF) state_nxt = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_done && bit_cnt == DATA_LAST) state_nxt = PARITY;
      PARITY: if (bit_done) state_nxt = STOP;
`else
      DATA:   if (bit_done && bit_cnt == DATA_LAST) state_nxt = STOP;
`endif
      STOP:   if (bit_done && (!rxd_s || bit_cnt == STOP_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy flag and the end-of-frame pulse decisions (registered below).
  always_comb begin
    busy      = (state != IDLE);
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt  = 1'b0;
`endif
    if (state == STOP && bit_done) begin
      if (!rxd_s) begin
        ferr_nxt = 1'b1;
      end else if (bit_cnt == STOP_LAST) begin
`ifdef UART_RX_PARITY_EN
        if (par_bad) perr_nxt  = 1'b1;
        else         valid_nxt = 1'b1;
`else
        valid_nxt = 1'b1;
`endif
      end
    end
  end

  // Datapath: synchroniser, bit timing, shift register, armed flag, outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      armed     <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;

      if (valid_nxt) rx_data <= shreg;

      // A low stop sample disarms until the line is seen high again.
      if (ferr_nxt)   armed <= 1'b0;
      else if (rxd_s) armed <= 1'b1;

      if (state == IDLE || state_nxt != state || bit_done) cnt <= '0;
      else                                                 cnt <= cnt + CW'(1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_done)      bit_cnt <= bit_cnt + BW'(1);

      if (state == DATA && bit_done) shreg <= {rxd_s, shreg[DATA_W-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check over data plus the received parity bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_nxt;
      if (state == PARITY && bit_done) par_bad <= ((^shreg) ^ rxd_s) != PAR_ODD;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: two receivers on one line (1 stop/even parity
// and 2 stop/odd parity), checked against an event-level reference model.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    int            kind;   // 1 = valid, 2 = frame error, 3 = parity error
    int            t;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          rxd = 1'b1;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b, busy_a, busy_b;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_errs = 0;
  int            busy_cnt_a = 0;
  int            busy_cnt_b = 0;
  ev_t           act_a[$], act_b[$], exp_a[$], exp_b[$];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .n_rst(n_rst), .rxd(rxd), .rx_data(data_a), .rx_valid(valid_a),
    .frame_err(ferr_a), .parity_err(perr_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .rxd(rxd), .rx_data(data_b), .rx_valid(valid_b),
    .frame_err(ferr_b), .parity_err(perr_b), .busy(busy_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int kind, input int t, input logic [DW-1:0] d);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    e.data = d;
    return e;
  endfunction

  // Record every output pulse with its cycle stamp.
  always @(negedge clk) begin
    if (valid_a) act_a.push_back(mk_ev(1, cyc, data_a));
    if (ferr_a)  act_a.push_back(mk_ev(2, cyc, data_a));
    if (perr_a)  act_a.push_back(mk_ev(3, cyc, data_a));
    if (valid_b) act_b.push_back(mk_ev(1, cyc, data_b));
    if (ferr_b)  act_b.push_back(mk_ev(2, cyc, data_b));
    if (perr_b)  act_b.push_back(mk_ev(3, cyc, data_b));
    if (busy_a)  busy_cnt_a++;
    if (busy_b)  busy_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: outcome of one frame from the framing rules alone.
  // t0 is the cycle of the edge that first registers the start bit.
  function automatic ev_t predict(input int t0, input logic [DW-1:0] d, input logic par_bit,
                                  input bit stop_ok, input int stops, input int odd);
    ev_t e;
    int  ones;
    ones   = $countones(d) + int'(par_bit);
    e.data = d;
    if (!stop_ok) begin
      e.kind = 2;
      e.t    = t0 + 2 + H + (DW + PB + 1) * CPB;
    end else begin
      e.t    = t0 + 2 + H + (DW + PB + stops) * CPB;
      e.kind = (PB == 1 && (ones % 2) != odd) ? 3 : 1;
    end
    return e;
  endfunction

  // Line always carries two stop bits on good frames; a bad frame drives the
  // first stop bit low and then holds the line low for 'hold' more cycles.
  task automatic send_frame(input logic [DW-1:0] d, input logic par_bit, input bit stop_ok,
                            input int hold, input int gap);
    int  t0;
    ev_t e;
    rxd = 1'b0;
    t0  = cyc + 1;
    wait_clk(CPB);
    for (int i = 0; i < DW; i++) begin
      rxd = d[i];
      wait_clk(CPB);
    end
    if (PB == 1) begin
      rxd = par_bit;
      wait_clk(CPB);
    end
    e = predict(t0, d, par_bit, stop_ok, 1, 0);
    exp_a.push_back(e);
    if (e.kind == 1) last_a = d;
    e = predict(t0, d, par_bit, stop_ok, 2, 1);
    exp_b.push_back(e);
    if (e.kind == 1) last_b = d;
    if (stop_ok) begin
      rxd = 1'b1;
      wait_clk(2 * CPB);
    end else begin
      rxd = 1'b0;
      wait_clk(CPB);
      busy_cnt_a = 0;
      busy_cnt_b = 0;
      wait_clk(hold);
      check("break_busy_a", busy_cnt_a, 0);
      check("break_busy_b", busy_cnt_b, 0);
      rxd = 1'b1;
      if (gap < 4) gap = 4;
    end
    wait_clk(gap);
  endtask

  task automatic glitch(input int len);
    busy_cnt_a = 0;
    busy_cnt_b = 0;
    rxd = 1'b0;
    wait_clk(len);
    rxd = 1'b1;
    wait_clk(H + 6);
    check("glitch_busy_a", busy_cnt_a, H);
    check("glitch_busy_b", busy_cnt_b, H);
  endtask

  task automatic compare_q(input string tag, input ev_t act[$], input ev_t exp[$]);
    check({tag, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) begin
      check({tag, "_kind"}, act[i].kind, exp[i].kind);
      check({tag, "_time"}, act[i].t, exp[i].t);
      if (exp[i].kind == 1) check({tag, "_data"}, act[i].data, exp[i].data);
    end
  endtask

  task automatic end_step(input string tag);
    wait_clk(2);
    compare_q({tag, "_a"}, act_a, exp_a);
    compare_q({tag, "_b"}, act_b, exp_b);
    check({tag, "_hold_a"}, data_a, last_a);
    check({tag, "_hold_b"}, data_b, last_b);
    check({tag, "_idle_a"}, busy_a, 0);
    check({tag, "_idle_b"}, busy_b, 0);
    act_a.delete();
    act_b.delete();
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic reset_mid_frame(input logic [DW-1:0] d);
    rxd = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      wait_clk(CPB);
    end
    rxd = d[4];
    wait_clk(H);
    check("rst_pre_busy_a", busy_a, 1);
    check("rst_pre_busy_b", busy_b, 1);
    n_rst = 1'b0;
    #1;
    check("rst_data_a", data_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_pulses_a", {valid_a, ferr_a, perr_a}, 0);
    check("rst_pulses_b", {valid_b, ferr_b, perr_b}, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    last_a = '0;
    last_b = '0;
    rxd = 1'b1;
    wait_clk(3);
    n_rst = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          pbit;
    int            sel;

    wait_clk(3);
    check("por_data_a", data_a, 0);
    check("por_out_a", {valid_a, ferr_a, perr_a, busy_a}, 0);
    check("por_out_b", {valid_b, ferr_b, perr_b, busy_b}, 0);
    n_rst = 1'b1;
    wait_clk(5);

    send_frame(8'hA5, ^8'hA5, 1'b1, 0, 10);
    end_step("t1_a5");

    glitch(4);
    end_step("t2_glitch");

    send_frame(8'h3C, ^8'h3C, 1'b0, 40, 6);
    send_frame(8'h12, ^8'h12, 1'b1, 0, 6);
    end_step("t3_break");

    send_frame(8'h00, 1'b0, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0, 8);
    end_step("t4_b2b");

    reset_mid_frame(8'hC3);
    send_frame(8'h5A, ^8'h5A, 1'b1, 0, 6);
    end_step("t5_reset");

    send_frame(8'h07, 1'b0, 1'b1, 0, 3);
    send_frame(8'h07, 1'b1, 1'b1, 0, 3);
    end_step("t6_parity");

    for (int n = 0; n < 30; n++) begin
      sel  = int'($urandom_range(0, 9));
      d    = DW'($urandom);
      pbit = 1'($urandom);
      if (sel < 7) begin
        send_frame(d, pbit, 1'b1, 0, int'($urandom_range(0, 20)));
        if (sel < 3) send_frame(~d, ~pbit, 1'b1, 0, 0);
      end else if (sel == 7) begin
        glitch(int'($urandom_range(1, H)));
      end else begin
        send_frame(d, pbit, 1'b0, int'($urandom_range(0, 50)), int'($urandom_range(0, 10)));
      end
      end_step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
